gpio_mmio_irq: RTL
==================

// Module: gpio_mmio_irq
// PURPOSE
// - Parametrised memory-mapped GPIO with NCH input and NCH output channels of DW bits each, on the processor data bus.
// - Inputs pass through a 2-flop synchroniser into per-bit rising-edge detection.
// - Edges set sticky status bits (write-1-to-clear); masked status raises a registered IRQ line to the core.
// PARAMETERS
// - DW          32  data/channel width in bits
// - NCH         2   channels per direction; power of 2, >=2
// - CHW         $clog2(NCH)  channel-index width (derived, localparam)
// - AW          CHW+2        address width (derived, localparam)
// - DEB_CYCLES  4   stable cycles needed before input accepted (GPIO_DEBOUNCE_EN only), >=1
// PORTS
// - CLK   in   1       clock, rising-edge
// - RST   in   1       reset, asynchronous, active-high
// - A     in   AW      word address {region[1:0], ch[CHW-1:0]}
// - WE    in   1       write enable, sampled on CLK rise
// - WD    in   DW      write data
// - gpi   in   NCH*DW  async inputs; channel i = gpi[i*DW +: DW]
// - RD    out  DW      read data, combinational from A
// - gpo   out  NCH*DW  output registers; channel i = gpo[i*DW +: DW]
// - IRQ   out  1       registered interrupt request
// BEHAVIOUR
// - Regions: 00 GPI data (RO); 01 GPO data (RW); 10 edge status (R, W1C); 11 IRQ mask (RW).
// - Reset (async): gpo=0, status=0, mask=0, sync stages=0, prev=0, IRQ=0, debounce state=0.
// - Writes on CLK rise when WE=1. GPO/mask: reg<=WD. Status: status<=status & ~WD. GPI region writes ignored.
// - RD = selected register, same cycle, no latency; GPI reads return the synchronised (debounced) value.
// - Input path per channel: s1<=gpi; s2<=s1; val=s2 (or debounced value); prev<=val.
// - Edge = val & ~prev, per bit. status<=(status & ~w1c_mask) | edge. Same-cycle W1C and new edge on same bit: edge wins, bit stays 1.
// - IRQ <= |(status[i] & mask[i]) over all channels, all bits; one cycle after status/mask change.
// - Latency (no debounce): gpi change before rise 1 -> visible on RD after rise 2 -> status set at rise 3 -> IRQ at rise 4.
// - Only rising edges are recorded; falling edges are ignored. Pulses shorter than one CLK period may be missed.
// - A pin held high through reset release sets its status bit on the 3rd rise after release (prev resets to 0).
// - Reset mid-operation clears everything immediately, including pending status and IRQ. No partial state survives.
// - gpo changes are visible at the port on the same rise as the write; a write to GPO does not affect status.
// CONFIGURATION
// - GPIO_DEBOUNCE_EN defined: per channel, one counter of width $clog2(DEB_CYCLES+1). While s2 != deb, count++; else count=0.
//   deb<=s2 and count<=0 when count reaches DEB_CYCLES-1 with s2 still != deb; val=deb. Adds DEB_CYCLES cycles of latency.
//   Any glitch that returns to deb before the limit is discarded.
// - GPIO_DEBOUNCE_EN undefined: val=s2; no counters are instantiated.
// TESTING (NCH=2, DW=32: addresses GPI0=0, GPI1=1, GPO0=2, GPO1=3, STAT0=4, STAT1=5, MASK0=6, MASK1=7)
// - Reset: RST=1 one cycle -> gpo=0, IRQ=0, RD=0 at A=2..7.
// - GPO write: WE=1, A=3, WD=32'hDEADBEEF -> gpo[63:32]=32'hDEADBEEF after rise; RD=32'hDEADBEEF at A=3; gpo[31:0] unchanged.
// - Sync/edge: gpi[31:0] 0->5 -> RD@A=0 = 5 after 2 rises; RD@A=4 = 5 after 3rd rise; IRQ stays 0 (mask=0).
// - IRQ: write MASK0=1 with STAT0=5 -> IRQ=1 one rise later; W1C STAT0 with WD=1 -> STAT0=4, IRQ=0 next rise.
// - Collision: W1C bit 0 of STAT1 on the same rise as a new rising edge on gpi[32] -> STAT1[0] remains 1.
// - Debounce (GPIO_DEBOUNCE_EN, DEB_CYCLES=4): 2-cycle glitch on gpi[0] -> no status set; 6-cycle high on gpi[0] -> STAT0[0]=1.

Source files
------------

// File: rtl/gpio_mmio_irq.sv
// Memory-mapped GPIO with NCH input and NCH output channels, sticky rising-edge status (W1C) and a masked IRQ.
// Optional input debounce is enabled by defining GPIO_DEBOUNCE_EN; DEB_CYCLES exists only in that build.
module gpio_mmio_irq #(
    parameter  int DW         = 32,
    parameter  int NCH        = 2,
`ifdef GPIO_DEBOUNCE_EN
    parameter  int DEB_CYCLES = 4,
`endif
    localparam int CHW        = $clog2(NCH),
    localparam int AW         = CHW + 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [AW-1:0]     A,
    input  logic              WE,
    input  logic [DW-1:0]     WD,
    input  logic [NCH*DW-1:0] gpi,
    output logic [DW-1:0]     RD,
    output logic [NCH*DW-1:0] gpo,
    output logic              IRQ
);

    typedef enum logic [1:0] {
        REG_GPI  = 2'b00,
        REG_GPO  = 2'b01,
        REG_STAT = 2'b10,
        REG_MASK = 2'b11
    } region_t;

    region_t         region;
    logic [CHW-1:0]  ch;

    logic [NCH-1:0][DW-1:0] s1, s2, val, prev;
    logic [NCH-1:0][DW-1:0] rise, w1c;
    logic [NCH-1:0][DW-1:0] gpo_q, status, mask;

    assign region = region_t'(A[AW-1:CHW]);
    assign ch     = A[CHW-1:0];
    assign gpo    = gpo_q;

    // Two-flop synchroniser; prev holds the accepted value from the previous cycle.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1   <= '0;
            s2   <= '0;
            prev <= '0;
        end else begin
            s1   <= gpi;
            s2   <= s1;
            prev <= val;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [NCH-1:0][DW-1:0] deb;
    logic [NCH-1:0][CW-1:0] cnt;

    // A channel word is accepted only after it has differed from deb for DEB_CYCLES consecutive cycles.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            deb <= '0;
            cnt <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (s2[i] != deb[i]) begin
                    if (cnt[i] == CW'(DEB_CYCLES - 1)) begin
                        deb[i] <= s2[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    assign val = deb;
`else
    assign val = s2;
`endif

    assign rise = val & ~prev;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w1c = '0;
        if (WE && region == REG_STAT) begin
            w1c[ch] = WD;
        end
    end

    // A new edge ORs in after the clear, so a same-cycle W1C never hides it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            gpo_q  <= '0;
            status <= '0;
            mask   <= '0;
            IRQ    <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (WE && ch == CHW'(i)) begin
                    if (region == REG_GPO)  gpo_q[i] <= WD;
                    if (region == REG_MASK) mask[i]  <= WD;
                end
                status[i] <= (status[i] & ~w1c[i]) | rise[i];
            end
            IRQ <= |(status & mask);
        end
    end

    always_comb begin
        RD = '0;
        case (region)
            REG_GPI:  RD = val[ch];
            REG_GPO:  RD = gpo_q[ch];
            REG_STAT: RD = status[ch];
            REG_MASK: RD = mask[ch];
            default:  RD = '0;
        endcase
    end

endmodule
